// File: rtl/cdc_sync_pkg.sv
// Shared constants and helpers for the single-bit synchroniser bank.
package cdc_sync_pkg;

  localparam int unsigned MIN_STAGES = 2;
  localparam int unsigned MAX_CH     = 256;

  // Width of a counter that must hold 0..len, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned len);
    int unsigned w;
    w = $clog2(len + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int unsigned popcount(input logic [MAX_CH-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      c += 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/cdc_sync_chan.sv
// One synchroniser channel: flop chain, optional stability filter and
// rise/fall pulse generation from the filtered level.
module cdc_sync_chan
  import cdc_sync_pkg::*;
#(
  parameter int unsigned STAGES     = 2,
  parameter int unsigned FILTER_LEN = 0,
  parameter logic        RESET_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  if (STAGES < MIN_STAGES) begin : g_bad_stages
    $error("cdc_sync_chan: STAGES must be at least 2");
  end

  logic [STAGES-1:0] stage;
  logic              s_last;
  logic              sync_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= {STAGES{RESET_VAL}};
    end else begin
      stage <= {stage[STAGES-2:0], async_in};
    end
  end

  assign s_last = stage[STAGES-1];

  if (FILTER_LEN == 0) begin : g_no_filter
    assign sync_out = s_last;
  end else begin : g_filter
    localparam int unsigned FW = cnt_width(FILTER_LEN);

    logic [FW-1:0] fcnt;
    logic          sync_r;

    // Accept a new level only after FILTER_LEN consecutive mismatching cycles.
    always_ff @(posedge clk) begin
      if (rst) begin
        fcnt   <= '0;
        sync_r <= RESET_VAL;
      end else if (s_last != sync_r) begin
        if (fcnt == FW'(FILTER_LEN - 1)) begin
          sync_r <= s_last;
          fcnt   <= '0;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end else begin
        fcnt <= '0;
      end
    end

    assign sync_out = sync_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_out_q <= RESET_VAL;
    end else begin
      sync_out_q <= sync_out;
    end
  end

  assign rise_pulse = sync_out & ~sync_out_q;
  assign fall_pulse = ~sync_out & sync_out_q;

endmodule

// File: rtl/cdc_sync_bank.sv
// Bank of independent single-bit synchronisers with a shared saturating
// counter of rise and fall events across all channels.
module cdc_sync_bank
  import cdc_sync_pkg::*;
#(
  parameter int unsigned        NUM_CH     = 4,
  parameter int unsigned        STAGES     = 2,
  parameter int unsigned        FILTER_LEN = 0,
  parameter logic [NUM_CH-1:0]  RESET_VAL  = '0,
  parameter int unsigned        CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] async_in,
  output logic [NUM_CH-1:0] sync_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  edge_cnt
);

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("cdc_sync_bank: NUM_CH out of range");
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    cdc_sync_chan #(
      .STAGES     (STAGES),
      .FILTER_LEN (FILTER_LEN),
      .RESET_VAL  (RESET_VAL[g])
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .async_in   (async_in[g]),
      .sync_out   (sync_out[g]),
      .rise_pulse (rise_pulse[g]),
      .fall_pulse (fall_pulse[g])
    );
  end

  // Sum is wide enough for the counter plus a full bank of events.
  localparam int unsigned SUM_W = ((CNT_W >= 9) ? CNT_W : 9) + 1;

  logic [NUM_CH-1:0] events;
  int unsigned       n_events;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  cnt_max;

  assign events   = rise_pulse | fall_pulse;
  assign n_events = popcount(MAX_CH'(events));
  assign cnt_max  = SUM_W'({CNT_W{1'b1}});
  assign sum      = SUM_W'(edge_cnt) + SUM_W'(n_events);

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      edge_cnt <= '0;
    end else if (sum > cnt_max) begin
      edge_cnt <= {CNT_W{1'b1}};
    end else begin
      edge_cnt <= CNT_W'(sum);
    end
  end

endmodule

// File: tb/tb_cdc_sync_bank.sv
// Bench for cdc_sync_bank: a filtered instance and an unfiltered deeper
// instance share stimulus and are both checked against a cycle model.
module tb_cdc_sync_bank;

  logic        clk;
  logic        rst;
  logic [3:0]  async_in;
  logic        cnt_clr;

  logic [3:0]  sync_a, rise_a, fall_a;
  logic [3:0]  cnt_a;
  logic [3:0]  sync_b, rise_b, fall_b;
  logic [15:0] cnt_b;

  int n_checks = 0;
  int n_pass   = 0;

  cdc_sync_bank #(
    .NUM_CH(4), .STAGES(2), .FILTER_LEN(3), .RESET_VAL(4'b0000), .CNT_W(4)
  ) dut_a (
    .clk(clk), .rst(rst), .async_in(async_in), .sync_out(sync_a),
    .rise_pulse(rise_a), .fall_pulse(fall_a), .cnt_clr(cnt_clr), .edge_cnt(cnt_a)
  );

  cdc_sync_bank #(
    .NUM_CH(4), .STAGES(3), .FILTER_LEN(0), .RESET_VAL(4'b0100), .CNT_W(16)
  ) dut_b (
    .clk(clk), .rst(rst), .async_in(async_in), .sync_out(sync_b),
    .rise_pulse(rise_b), .fall_pulse(fall_b), .cnt_clr(cnt_clr), .edge_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Cycle model: per instance, a history of sampled inputs and the accepted level.
  int          stg  [2] = '{2, 3};
  int          fl   [2] = '{3, 0};
  logic [3:0]  rv   [2] = '{4'b0000, 4'b0100};
  int          cmax [2] = '{15, 65535};

  logic [3:0]  m_hist  [2][4];
  logic [3:0]  m_sync  [2];
  logic [3:0]  m_syncq [2];
  int          m_run   [2][4];
  int          m_cnt   [2];
  logic [3:0]  m_sl;
  int          m_n;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int k = 0; k < 4; k++) m_hist[d][k] = rv[d];
        for (int c = 0; c < 4; c++) m_run[d][c] = 0;
        m_sync[d]  = rv[d];
        m_syncq[d] = rv[d];
        m_cnt[d]   = 0;
      end else begin
        m_n = $countones(m_sync[d] ^ m_syncq[d]);
        if (cnt_clr) m_cnt[d] = 0;
        else m_cnt[d] = (m_cnt[d] + m_n > cmax[d]) ? cmax[d] : m_cnt[d] + m_n;
        m_sl = m_hist[d][stg[d]-1];
        m_syncq[d] = m_sync[d];
        for (int k = 3; k > 0; k--) m_hist[d][k] = m_hist[d][k-1];
        m_hist[d][0] = async_in;
        if (fl[d] == 0) begin
          m_sync[d] = m_hist[d][stg[d]-1];
        end else begin
          for (int c = 0; c < 4; c++) begin
            if (m_sl[c] != m_sync[d][c]) begin
              m_run[d][c]++;
              if (m_run[d][c] == fl[d]) begin
                m_sync[d][c] = m_sl[c];
                m_run[d][c]  = 0;
              end
            end else begin
              m_run[d][c] = 0;
            end
          end
        end
      end
    end
    #1;
    check("a_sync", 32'(sync_a), 32'(m_sync[0]));
    check("a_rise", 32'(rise_a), 32'(m_sync[0] & ~m_syncq[0]));
    check("a_fall", 32'(fall_a), 32'(~m_sync[0] & m_syncq[0]));
    check("a_cnt",  32'(cnt_a),  32'(m_cnt[0]));
    check("b_sync", 32'(sync_b), 32'(m_sync[1]));
    check("b_rise", 32'(rise_b), 32'(m_sync[1] & ~m_syncq[1]));
    check("b_fall", 32'(fall_b), 32'(~m_sync[1] & m_syncq[1]));
    check("b_cnt",  32'(cnt_b),  32'(m_cnt[1]));
  end

  initial begin
    rst      = 1'b1;
    async_in = 4'hF;
    cnt_clr  = 1'b0;

    // Reset with all inputs high.
    repeat (3) @(negedge clk);
    check("rst_a_sync", 32'(sync_a), 32'h0);
    check("rst_a_rise", 32'(rise_a), 32'h0);
    check("rst_a_cnt",  32'(cnt_a),  32'h0);
    check("rst_b_sync", 32'(sync_b), 32'h4);
    rst = 1'b0;

    repeat (2) @(negedge clk);
    check("lat_b_early", 32'(sync_b), 32'h4);
    @(negedge clk);
    check("lat_b_sync", 32'(sync_b), 32'hF);
    check("lat_b_rise", 32'(rise_b), 32'hB);
    @(negedge clk);
    check("lat_a_early", 32'(sync_a), 32'h0);
    check("lat_b_rise0", 32'(rise_b), 32'h0);
    check("lat_b_cnt",  32'(cnt_b),  32'd3);
    @(negedge clk);
    check("rel_a_sync", 32'(sync_a), 32'hF);
    check("rel_a_rise", 32'(rise_a), 32'hF);
    @(negedge clk);
    check("rel_a_rise0", 32'(rise_a), 32'h0);
    check("rel_a_cnt",  32'(cnt_a),  32'd4);

    // Glitch filter: 2-cycle excursion swallowed, 3-cycle one accepted.
    async_in = 4'h0;
    repeat (10) @(negedge clk);
    check("fall_a_cnt", 32'(cnt_a), 32'd8);
    async_in = 4'b0010;
    repeat (2) @(negedge clk);
    async_in = 4'h0;
    repeat (10) @(negedge clk);
    check("glitch_a_sync", 32'(sync_a), 32'h0);
    check("glitch_a_cnt",  32'(cnt_a),  32'd8);
    async_in = 4'b0010;
    repeat (3) @(negedge clk);
    async_in = 4'h0;
    @(negedge clk);
    check("pass_a_early", 32'(sync_a), 32'h0);
    @(negedge clk);
    check("pass_a_sync", 32'(sync_a), 32'b0010);
    check("pass_a_rise", 32'(rise_a), 32'b0010);
    repeat (10) @(negedge clk);
    check("pass_a_cnt", 32'(cnt_a), 32'd10);

    // Simultaneous rise on ch0 and fall on ch2.
    async_in = 4'b0100;
    repeat (10) @(negedge clk);
    async_in = 4'b0001;
    repeat (5) @(negedge clk);
    check("simul_a_rise", 32'(rise_a), 32'b0001);
    check("simul_a_fall", 32'(fall_a), 32'b0100);
    @(negedge clk);
    check("simul_a_cnt", 32'(cnt_a), 32'd13);

    // Saturation of the 4-bit counter.
    for (int i = 0; i < 4; i++) begin
      async_in = (i % 2 == 0) ? 4'hF : 4'h0;
      repeat (8) @(negedge clk);
    end
    check("sat_a_cnt", 32'(cnt_a), 32'd15);

    // Clear wins over a same-cycle two-channel event.
    async_in = 4'b0011;
    repeat (5) @(negedge clk);
    check("clr_a_rise", 32'(rise_a), 32'b0011);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("clr_a_cnt", 32'(cnt_a), 32'd0);
    repeat (3) @(negedge clk);
    check("clr_a_cnt_hold", 32'(cnt_a), 32'd0);

    // Reset while ch3 is part-way through its filter window.
    async_in = 4'b1011;
    repeat (4) @(negedge clk);
    check("mid_a_pre", 32'(sync_a), 32'b0011);
    rst = 1'b1;
    @(negedge clk);
    check("mid_a_rst_sync", 32'(sync_a), 32'h0);
    check("mid_a_rst_cnt",  32'(cnt_a),  32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_a_early", 32'(sync_a), 32'h0);
    @(negedge clk);
    check("mid_a_sync", 32'(sync_a), 32'b1011);
    check("mid_a_rise", 32'(rise_a), 32'b1011);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
